cur_mb_loader: RTL and testbench
================================

// Module: cur_mb_loader
// PURPOSE
// - Fetches one 16x16 current-frame macroblock (MB) from the current-frame byte memory.
// - The memory is a 32-bit read port, little-endian, with a combinational read.
// - Buffers the MB and streams it row by row to the ME PE array over a valid/ready handshake.
// - Sits between the current-frame memory (upstream) and the SAD/PE array (downstream).
// PARAMETERS
// - MB_SIZE    16         MB edge in pixels; must be a multiple of 4
// - FRAME_W    1920       frame width in pixels (bytes per line)
// - FRAME_H    1088       frame height in lines
// - BASE_ADDR  32'h0      byte address of pixel (0,0) in the current-frame memory
// PORTS
// - clk        in   1             system clock, rising edge
// - rst        in   1             asynchronous, active-high reset
// - start      in   1             1-cycle request to load the MB at (mb_x, mb_y)
// - mb_x       in   8             MB column index
// - mb_y       in   8             MB row index
// - busy       out  1             high from the cycle after an accepted start until done
// - done       out  1             1-cycle pulse after the last row is accepted, or on err
// - err        out  1             MB lies outside the frame; valid while done=1
// - mem_en     out  1             memory read enable
// - mem_addr   out  32            memory byte address (word = addr..addr+3)
// - mem_data   in   32            read data, same cycle; byte addr+k on bits [8k+7:8k]
// - row_valid  out  1             row_data / row_idx valid
// - row_ready  in   1             downstream accepts the row
// - row_data   out  MB_SIZE*8     one MB row; pixel p on bits [8p+7:8p]
// - row_idx    out  4             row number 0..MB_SIZE-1
// BEHAVIOUR
// - Reset: all outputs 0; FSM in IDLE; buffer contents don't-care.
// - IDLE: on start, latch mb_x and mb_y. If (mb_x+1)*MB_SIZE > FRAME_W or (mb_y+1)*MB_SIZE > FRAME_H:
//     go to ERR. Otherwise go to FETCH with r=0, w=0.
// - start while busy: ignored, no effect on the latched MB coordinates.
// - FETCH: mem_en=1.
//     mem_addr = BASE_ADDR + (mb_y*MB_SIZE + r)*FRAME_W + mb_x*MB_SIZE + 4*w. Computed in 32 bits, no wrap check.
//     At each posedge, mem_data is written to buffer row r, pixels 4w..4w+3.
//     w increments 0..MB_SIZE/4-1, then wraps to 0 and r increments.
//     After the word (r=MB_SIZE-1, w=last), go to STREAM. Takes exactly MB_SIZE*MB_SIZE/4 cycles (64 by default).
// - Outside FETCH: mem_en=0 and mem_addr=0.
// - STREAM: row_valid=1, row_idx=k, row_data=buffer[k], k starting at 0.
//     k advances only on row_valid&&row_ready.
//     While ready is low, row_data and row_idx are held stable.
//     Acceptance of k=MB_SIZE-1 leads to DONE. The minimum is MB_SIZE cycles.
// - DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE. A start in the DONE cycle is ignored.
// - ERR: done=1 and err=1 for one cycle, with no memory access and no rows, then IDLE.
// - busy=1 in FETCH and STREAM only.
// - Total latency with ready always high: start to done = 1 + 64 + 16 + 1 cycles = 82 cycles.
// - Reset mid-operation (async) aborts immediately: outputs go to 0, no partial row and no done.
// STRUCTURE
// - Shared package me_pkg holds:
//     MB_SIZE and PIX_W=8 constants;
//     state enum {IDLE, FETCH, STREAM, DONE, ERR};
//     the row-vector typedef.
// - Sub-module cur_addr_gen: latches the MB base on load, then steps r/w and emits mem_addr plus a last flag.
//     The base is computed once per start; each step adds 4 or (FRAME_W - MB_SIZE + 4), so no per-cycle multiply.
// - The top level holds the FSM, the MB_SIZE x (MB_SIZE*8) buffer and the stream counter.
// TESTING
// - Reset then idle: all outputs 0, mem_en=0, no done for 100 cycles.
// - Load at mb_x=0, mb_y=0 with memory byte[a]=a[7:0]:
//     first mem_addr=0, second 4, and addr 1920 at r=1,w=0;
//     row0 = bytes 0x00..0x0F (pixel0=0x00);
//     done at cycle 82 after start.
// - Load at mb_x=3, mb_y=2 with row_ready toggled 1-0-1-0:
//     first mem_addr=32*1920+48=61488;
//     row_data stable while ready is low;
//     row_idx 0..15 in order, each exactly once.
// - Load at mb_x=120, mb_y=0 (120*16+16 > 1920):
//     err=1 and done=1 one cycle after start;
//     mem_en never asserted; row_valid never asserted.
// - start pulsed in the middle of FETCH: ignored, and the output MB matches the original coordinates.
// - rst asserted during STREAM at row 7: outputs are 0 on the same edge; a fresh start then loads and streams correctly.

Source files
------------

// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimation datapath.
package me_pkg;

   localparam int MB_SIZE = 16;
   localparam int PIX_W   = 8;
   localparam int WORDS   = MB_SIZE / 4;
   localparam int ROW_W   = $clog2(MB_SIZE);
   localparam int WORD_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef logic [MB_SIZE*PIX_W-1:0] row_t;
   typedef logic [ROW_W-1:0]         ridx_t;
   typedef logic [WORD_W-1:0]        widx_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_STREAM,
      S_DONE,
      S_ERR
   } state_e;

endpackage

// File: rtl/cur_addr_gen.sv
// Walks the MB word by word; base multiply happens only on load.
module cur_addr_gen
   import me_pkg::*;
#(
   parameter int          FRAME_W   = 1920,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        step_i,
   input  logic [7:0]  mb_x_i,
   input  logic [7:0]  mb_y_i,
   output logic [31:0] addr_o,
   output ridx_t       row_o,
   output widx_t       word_o,
   output logic        last_o
);

   localparam logic [31:0] LINE  = 32'(MB_SIZE * FRAME_W);
   localparam logic [31:0] WRAP  = 32'(FRAME_W - MB_SIZE + 4);
   localparam widx_t       WLAST = WORD_W'(WORDS - 1);
   localparam ridx_t       RLAST = ROW_W'(MB_SIZE - 1);

   logic [31:0] addr_q, addr_d;
   ridx_t       row_q, row_d;
   widx_t       word_q, word_d;
   logic [31:0] base;

   assign base = BASE_ADDR
               + 32'(mb_y_i) * LINE
               + 32'(mb_x_i) * 32'(MB_SIZE);

   always_comb begin
      addr_d = addr_q;
      row_d  = row_q;
      word_d = word_q;
      if (load_i) begin
         addr_d = base;
         row_d  = '0;
         word_d = '0;
      end else if (step_i) begin
         if (word_q == WLAST) begin
            // jump to the first word of the next MB line
            addr_d = addr_q + WRAP;
            word_d = '0;
            row_d  = row_q + 1'b1;
         end else begin
            addr_d = addr_q + 32'd4;
            word_d = word_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         row_q  <= '0;
         word_q <= '0;
      end else begin
         addr_q <= addr_d;
         row_q  <= row_d;
         word_q <= word_d;
      end
   end

   assign addr_o = addr_q;
   assign row_o  = row_q;
   assign word_o = word_q;
   assign last_o = (row_q == RLAST) && (word_q == WLAST);

endmodule

// File: rtl/cur_mb_loader.sv
// Fetches one current-frame MB into a local buffer, then streams rows.
module cur_mb_loader
   import me_pkg::*;
#(
   parameter int          FRAME_W   = 1920,
   parameter int          FRAME_H   = 1088,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  mb_x,
   input  logic [7:0]  mb_y,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        mem_en,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   output logic        row_valid,
   input  logic        row_ready,
   output row_t        row_data,
   output ridx_t       row_idx
);

   localparam ridx_t KLAST = ROW_W'(MB_SIZE - 1);

   state_e state_q, state_d;
   ridx_t  k_q, k_d;
   row_t   buf_q [MB_SIZE];

   logic        ag_load;
   logic        ag_step;
   logic [31:0] ag_addr;
   ridx_t       ag_row;
   widx_t       ag_word;
   logic        ag_last;

   logic [31:0] x_end;
   logic [31:0] y_end;
   logic        in_frame;

   assign x_end = (32'(mb_x) + 32'd1) * 32'(MB_SIZE);
   assign y_end = (32'(mb_y) + 32'd1) * 32'(MB_SIZE);
   assign in_frame = (x_end <= 32'(FRAME_W))
                  && (y_end <= 32'(FRAME_H));

   cur_addr_gen #(
      .FRAME_W   (FRAME_W),
      .BASE_ADDR (BASE_ADDR)
   ) u_addr (
      .clk    (clk),
      .rst    (rst),
      .load_i (ag_load),
      .step_i (ag_step),
      .mb_x_i (mb_x),
      .mb_y_i (mb_y),
      .addr_o (ag_addr),
      .row_o  (ag_row),
      .word_o (ag_word),
      .last_o (ag_last)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      ag_load = 1'b0;
      ag_step = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ag_load = in_frame;
               k_d     = '0;
               state_d = in_frame ? S_FETCH : S_ERR;
            end
         end
         S_FETCH: begin
            ag_step = 1'b1;
            if (ag_last) state_d = S_STREAM;
         end
         S_STREAM: begin
            if (row_ready) begin
               if (k_q == KLAST) state_d = S_DONE;
               else              k_d     = k_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   // buffer content is don't-care after reset, so no reset branch
   always_ff @(posedge clk) begin
      if (state_q == S_FETCH)
         buf_q[ag_row][32*ag_word +: 32] <= mem_data;
   end

   assign busy      = (state_q == S_FETCH) || (state_q == S_STREAM);
   assign done      = (state_q == S_DONE) || (state_q == S_ERR);
   assign err       = (state_q == S_ERR);
   assign mem_en    = (state_q == S_FETCH);
   assign mem_addr  = mem_en ? ag_addr : 32'h0;
   assign row_valid = (state_q == S_STREAM);
   assign row_data  = row_valid ? buf_q[k_q] : '0;
   assign row_idx   = row_valid ? k_q : '0;

endmodule

// File: tb/tb_cur_mb_loader.sv
// Randomised self-checking bench for cur_mb_loader.
module tb_cur_mb_loader;
   import me_pkg::*;

   localparam int FW = 1920;
   localparam int FH = 1088;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  mb_x = '0;
   logic [7:0]  mb_y = '0;
   logic        busy, done, err, mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        row_valid;
   logic        row_ready = 1'b0;
   row_t        row_data;
   ridx_t       row_idx;

   int n_chk = 0;
   int n_fail = 0;

   int          pat = 0;
   logic [31:0] seed = 32'h1234_5678;

   logic [31:0] addr_exp[$];
   logic [31:0] addr_log[$];
   row_t        rows_exp [16];
   bit          rows_active = 0;
   int          exp_idx = 0;
   row_t        first_row;
   bit          got_first = 0;

   always #5 clk = ~clk;

   cur_mb_loader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mb_x      (mb_x),
      .mb_y      (mb_y),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .row_data  (row_data),
      .row_idx   (row_idx)
   );

   function automatic logic [7:0] fb(input logic [31:0] a);
      logic [31:0] t;
      if (pat == 0) return a[7:0];
      t = (a * 32'h9E37_79B1) ^ seed;
      return t[23:16];
   endfunction

   assign mem_data = {fb(mem_addr + 32'd3), fb(mem_addr + 32'd2),
                      fb(mem_addr + 32'd1), fb(mem_addr)};

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // per-cycle compare against the model queues
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_en) begin
            if (addr_exp.size() == 0) begin
               chk("mem_en_unexpected", 128'(mem_en), 128'd0);
            end else begin
               chk("mem_addr", 128'(mem_addr), 128'(addr_exp.pop_front()));
               addr_log.push_back(mem_addr);
            end
         end else begin
            chk("mem_addr_idle", 128'(mem_addr), 128'd0);
         end
         if (row_valid) begin
            if (!rows_active || exp_idx > 15) begin
               chk("row_valid_unexpected", 128'(row_valid), 128'd0);
            end else begin
               chk("row_idx", 128'(row_idx), 128'(exp_idx));
               chk("row_data", row_data, rows_exp[exp_idx]);
               if (!got_first) begin
                  first_row = row_data;
                  got_first = 1;
               end
               if (row_ready) exp_idx++;
            end
         end else begin
            chk("row_idle", {row_data[123:0], row_idx}, 128'd0);
         end
      end
   end

   function automatic logic [127:0] all_out();
      return {row_data[63:0], mem_addr, 20'd0, row_idx,
              busy, done, err, mem_en, row_valid};
   endfunction

   task automatic load(input int x, input int y, input int rmode,
                       input bit mid_start, input bit start_in_done,
                       input int abort_row);
      int n;
      bit bad;
      logic [31:0] a;
      bad = ((x + 1) * 16 > FW) || ((y + 1) * 16 > FH);
      addr_exp.delete();
      addr_log.delete();
      exp_idx = 0;
      got_first = 0;
      if (!bad) begin
         for (int r = 0; r < 16; r++) begin
            for (int w = 0; w < 4; w++)
               addr_exp.push_back(32'((y * 16 + r) * FW + x * 16 + 4 * w));
            for (int p = 0; p < 16; p++) begin
               a = 32'((y * 16 + r) * FW + x * 16 + p);
               rows_exp[r][8*p +: 8] = fb(a);
            end
         end
      end
      rows_active = !bad;
      @(posedge clk); #1;
      mb_x = 8'(x);
      mb_y = 8'(y);
      start = 1'b1;
      row_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mb_x = 8'($urandom);
      mb_y = 8'($urandom);
      n = 0;
      forever begin
         @(negedge clk);
         if (abort_row >= 0 && row_valid && row_idx == 4'(abort_row)) begin
            #1 rst = 1'b1;
            #1 chk("abort_outputs_zero", all_out(), 128'd0);
            chk("abort_row_data_zero", row_data, 128'd0);
            addr_exp.delete();
            rows_active = 0;
            return;
         end
         if (done) break;
         if (n == 0) chk("busy_after_start", 128'(busy), 128'd1);
         if (n >= 400) begin
            chk("done_timeout", 128'(n), 128'd0);
            break;
         end
         @(posedge clk); #1;
         n++;
         case (rmode)
            0:       row_ready = 1'b1;
            1:       row_ready = ~row_ready;
            default: row_ready = 1'($urandom_range(0, 1));
         endcase
         start = mid_start && (n == 10);
         if (start) begin
            mb_x = 8'($urandom_range(0, 119));
            mb_y = 8'($urandom_range(0, 67));
         end
      end
      chk("done", 128'(done), 128'd1);
      chk("err", 128'(err), 128'(bad));
      chk("busy_at_done", 128'(busy), 128'd0);
      if (rmode == 0)
         chk("start_to_done_cycles", 128'(n + 2), bad ? 128'd2 : 128'd82);
      chk("addr_all_issued", 128'(addr_exp.size()), 128'd0);
      chk("rows_streamed", 128'(exp_idx), bad ? 128'd0 : 128'd16);
      if (start_in_done) begin
         mb_x = 8'd1;
         mb_y = 8'd1;
         start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("after_done_idle", {busy, done, err, mem_en, row_valid}, 128'd0);
      rows_active = 0;
   endtask

   initial begin
      row_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", all_out(), 128'd0);
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle_outputs", all_out(), 128'd0);
      end

      pat = 0;
      load(0, 0, 0, 0, 0, -1);
      chk("first_addr", 128'(addr_log[0]), 128'd0);
      chk("second_addr", 128'(addr_log[1]), 128'd4);
      chk("row1_addr", 128'(addr_log[4]), 128'd1920);
      chk("row0_literal", first_row,
          128'h0F0E0D0C0B0A09080706050403020100);

      load(3, 2, 1, 0, 0, -1);
      chk("mb32_first_addr", 128'(addr_log[0]), 128'd61488);

      load(120, 0, 0, 0, 0, -1);
      load(0, 68, 0, 0, 0, -1);

      pat = 1;
      load(119, 67, 0, 0, 1, -1);
      load(7, 9, 2, 1, 0, -1);

      for (int t = 0; t < 6; t++) begin
         seed = $urandom;
         load($urandom_range(0, 121), $urandom_range(0, 69),
              $urandom_range(0, 2), t[0], t[1], -1);
      end

      load(5, 4, 0, 0, 0, 7);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("held_reset_outputs", all_out(), 128'd0);
      @(posedge clk); #1 rst = 1'b0;
      seed = $urandom;
      load(5, 4, 2, 0, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
